// File: rtl/regfile_dump_reader.sv
// Walks the register file read port from address 0 to NREGS-1 and streams each word over
// valid/ready. Optional XOR checksum beat when REGFILE_DUMP_CHECKSUM_EN is defined.
module regfile_dump_reader #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    output logic [AW-1:0] rd_addr_o,
    input  logic [DW-1:0] rd_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [AW-1:0] out_addr_o,
    output logic [DW-1:0] out_data_o,
    output logic          out_last_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam logic [AW-1:0] LastAddr = AW'(NREGS - 1);

`ifdef REGFILE_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {StIdle, StLoad, StSend, StSum, StFin} state_e;
`else
    typedef enum logic [2:0] {StIdle, StLoad, StSend, StFin} state_e;
`endif

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          valid_q, valid_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          last_q, last_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [DW-1:0] sum_q, sum_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            last_q  <= last_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        last_d  = last_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StLoad;
                    ptr_d   = '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            StLoad: begin
                // Word is sampled here, so writes landing before this cycle are visible.
                data_d  = rd_data_i;
                addr_d  = ptr_q;
                valid_d = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                sum_d   = sum_q ^ rd_data_i;
                last_d  = 1'b0;
`else
                last_d  = (ptr_q == LastAddr);
`endif
                state_d = StSend;
            end
            StSend: begin
                if (out_ready_i) begin
                    valid_d = 1'b0;
                    if (ptr_q != LastAddr) begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = StLoad;
                    end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        valid_d = 1'b1;
                        addr_d  = '0;
                        data_d  = sum_q;
                        last_d  = 1'b1;
                        state_d = StSum;
`else
                        state_d = StFin;
`endif
                    end
                end
            end
`ifdef REGFILE_DUMP_CHECKSUM_EN
            StSum: begin
                if (out_ready_i) begin
                    valid_d = 1'b0;
                    state_d = StFin;
                end
            end
`endif
            StFin: begin
                ptr_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign rd_addr_o   = ptr_q;
    assign out_valid_o = valid_q;
    assign out_addr_o  = addr_q;
    assign out_data_o  = data_q;
    assign out_last_o  = last_q;
    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StFin);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader; works with or without REGFILE_DUMP_CHECKSUM_EN.
module tb_regfile_dump_reader;

    localparam int NREGS = 32;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam int NB = NREGS + CK;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] regs     [NREGS];
    logic [31:0] exp_data [NB];

    int n_checks;
    int n_fail;
    int nbeats;
    int ndone;
    int last_hs;
    int done_t;

    assign rd_data = regs[rd_addr];

    regfile_dump_reader #(
        .NREGS(NREGS),
        .AW   (5),
        .DW   (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .rd_addr_o  (rd_addr),
        .rd_data_i  (rd_data),
        .out_valid_o(out_valid),
        .out_ready_i(ready),
        .out_addr_o (out_addr),
        .out_data_o (out_data),
        .out_last_o (out_last),
        .busy_o     (busy),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < NREGS; i++) regs[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
    endtask

    // Expected beats from the current regfile contents, plus checksum beat when compiled in.
    task automatic build_expected();
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < NREGS; i++) begin
            exp_data[i] = regs[i];
            s = s ^ regs[i];
        end
        if (CK == 1) exp_data[NB-1] = s;
    endtask

    // t counts edges after the start edge E0; a handshake seen at negedge t lands on E(t+1).
    task automatic run_dump(input int ready_mode, input int restart_beat, input bit do_write);
        bit          pv, pr, pl, pulsed, written;
        logic [4:0]  pa;
        logic [31:0] pd;
        nbeats = 0; ndone = 0; last_hs = -1; done_t = -1;
        pv = 0; pr = 0; pl = 0; pa = '0; pd = '0; pulsed = 0; written = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (t > 0) @(negedge clk);
            start = 1'b0;
            if (restart_beat >= 0 && !pulsed && nbeats == restart_beat && out_valid) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
            if (do_write && !written && rd_addr == 5'd10) begin
                regs[20] = 32'hCAFE_F00D;
                written  = 1'b1;
            end
            ready = (ready_mode == 0) ? 1'b1 : (t % 3 == 0);
            if (done) begin
                ndone++;
                done_t = t;
            end
            if (pv && !pr) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_addr", 32'(out_addr), 32'(pa));
                check("stall_data", out_data, pd);
                check("stall_last", 32'(out_last), 32'(pl));
            end
            if (out_valid && ready) begin
                if (nbeats >= NB) begin
                    check("extra_beat", 32'(nbeats), 32'(NB - 1));
                end else begin
                    check($sformatf("beat%0d_addr", nbeats), 32'(out_addr),
                          (nbeats < NREGS) ? 32'(nbeats) : 32'd0);
                    check($sformatf("beat%0d_data", nbeats), out_data, exp_data[nbeats]);
                    check($sformatf("beat%0d_last", nbeats), 32'(out_last),
                          32'(nbeats == NB - 1));
                end
                nbeats++;
                last_hs = t + 1;
            end
            pv = out_valid; pr = ready; pa = out_addr; pd = out_data; pl = out_last;
            if (t > 0 && !busy) break;
        end
        check("dump_terminated", 32'(busy), 32'd0);
        ready = 1'b0;
    endtask

    task automatic check_run(input string tag);
        check({tag, "_nbeats"}, 32'(nbeats), 32'(NB));
        check({tag, "_ndone"}, 32'(ndone), 32'd1);
        check({tag, "_done_t"}, 32'(done_t), 32'(last_hs));
    endtask

    initial begin
        bit found, saw_valid, saw_done;
        n_checks = 0; n_fail = 0;
        clk = 1'b0; rst_n = 1'b0; start = 1'b0; ready = 1'b0;
        fill_ramp();
        repeat (3) @(negedge clk);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_addr", 32'(out_addr), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Ramp contents, ready always high.
        build_expected();
        run_dump(0, -1, 1'b0);
        check_run("ramp");
        check("ramp_last_hs_cycle", 32'(last_hs), 32'(2 * NREGS + CK));

        // Same contents with back-pressure.
        run_dump(1, -1, 1'b0);
        check_run("stall");

        // Single non-zero register; checksum equals that word.
        for (int i = 0; i < NREGS; i++) regs[i] = 32'h0;
        regs[5] = 32'hDEAD_BEEF;
        build_expected();
        if (CK == 1) exp_data[NB-1] = 32'hDEAD_BEEF;
        run_dump(0, -1, 1'b0);
        check_run("sum");

        // Second start while busy is ignored; nothing follows.
        fill_ramp();
        build_expected();
        run_dump(0, 10, 1'b0);
        check_run("restart");
        saw_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            saw_valid |= out_valid | busy;
        end
        check("restart_no_second_dump", 32'(saw_valid), 32'd0);

        // Write to reg20 while reg10 is being read shows up in beat 20.
        fill_ramp();
        regs[20] = 32'hCAFE_F00D;
        build_expected();
        fill_ramp();
        run_dump(0, -1, 1'b1);
        check_run("write");

        // Reset during the SEND of addr 12 aborts the dump.
        fill_ramp();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            ready = 1'b1;
            if (out_valid && out_addr == 5'd12) begin
                ready = 1'b0;
                found = 1'b1;
                break;
            end
        end
        check("abort_reached_addr12", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_rd_addr", 32'(rd_addr), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_addr", 32'(out_addr), 32'd0);
        check("abort_data", out_data, 32'd0);
        check("abort_last", 32'(out_last), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        saw_valid = 1'b0;
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            saw_valid |= out_valid;
            saw_done |= done;
        end
        check("abort_no_valid", 32'(saw_valid), 32'd0);
        check("abort_no_done", 32'(saw_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Debug read-out engine for the 32×32 CPU register file. On a start pulse it walks the register file's asynchronous read port from address 0 to 31 and streams each word out over a valid/ready interface toward the debug/UART path. It owns one read port (address out, data in) and never writes the register file. With the checksum option compiled in, an XOR checksum beat follows the last register.

## Interface
Parameters:
- NREGS, 32, number of registers dumped, addresses 0..NREGS-1.
- AW, 5, register address width; 2^AW ≥ NREGS.
- DW, 32, register data width.

Ports:
- clk  in  1  single clock, all state updates on posedge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  request a dump; sampled only in IDLE.
- rd_addr  out  AW  register-file read address; registered, equals internal pointer.
- rd_data  in  DW  register-file read data; combinational response to rd_addr.
- out_valid  out  1  output beat valid.
- out_ready  in  1  sink accepts the beat.
- out_addr  out  AW  register index of the current beat; 0 on the checksum beat.
- out_data  out  DW  register value, or checksum on the checksum beat.
- out_last  out  1  final beat of the dump.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final handshake.

## Operation
- States:
  - IDLE: waits for start.
  - LOAD: captures rd_data.
  - SEND: holds the beat until accepted.
  - SUM: checksum beat; only present with the macro.
  - FIN: pulses done.
- IDLE → LOAD when start=1. On that edge, ptr←0 and sum←0.
- LOAD → SEND always. On that edge:
  - out_data←rd_data, out_addr←ptr, out_valid←1.
  - sum←sum^rd_data.
  - out_last←(ptr==NREGS-1) when the checksum is disabled; otherwise out_last←0.
- SEND: holds while out_valid && !out_ready. On a handshake, out_valid←0, then:
  - if ptr<NREGS-1: ptr←ptr+1, go to LOAD.
  - if ptr==NREGS-1: go to SUM if the checksum is enabled, else to FIN.
- FIN: done=1 for exactly this one cycle, then return to IDLE. ptr returns to 0.
- start is ignored while busy; there is no queuing.
- Each word is sampled in its own LOAD cycle. The dump is not atomic: a register-file write that lands before a register's LOAD cycle is visible in the dump.
- out_data, out_addr and out_last stay stable while out_valid=1 and out_ready=0.
- The ptr increment never wraps: the maximum value is NREGS-1.
- Reset mid-dump aborts immediately: all state and outputs are cleared, no done pulse is produced, and a partial beat is dropped.

## Timing
- Reset values: rd_addr=0, out_valid=0, out_addr=0, out_data=0, out_last=0, busy=0, done=0; internal state IDLE, ptr=0, sum=0.
- start sampled at edge E0 → state LOAD after E0, with rd_addr=0 in the following cycle.
- The first beat is valid after E1.
- With out_ready held at 1, each beat costs 2 cycles (LOAD + SEND).
- A full dump without checksum is 2·NREGS cycles from E0 to the last handshake; done follows 1 cycle later.
- busy rises after E0 and falls the edge after the FIN cycle.
- A new start is accepted in the first IDLE cycle.

## Configuration
- Macro: REGFILE_DUMP_CHECKSUM_EN.
- Defined: after the reg NREGS-1 handshake, the block enters SUM. The entry edge sets out_valid=1, out_addr=0, out_data=sum (XOR of all NREGS words), out_last=1. The checksum beat obeys the same hold rules as SEND; its handshake leads to FIN. A full dump takes 2·NREGS+1 cycles to the final handshake with ready high.
- Undefined: the SUM state and the sum register are absent. out_last is asserted on the reg NREGS-1 beat.

## Test plan
- Regfile with regs[i]=0x1000_0000+i (reg0=0), out_ready=1, start pulse → 32 beats with out_addr 0..31 and out_data matching, out_last only on addr 31 (no macro), done 1 cycle after the last handshake, 64 cycles from start to the last handshake.
- Same contents, out_ready toggled 1-of-3 cycles → identical beat sequence; out_data/out_addr held stable during each stall; no beat dropped or duplicated.
- With the macro, reg5=0xDEADBEEF and all others 0 → 33 beats, final beat out_addr=0, out_data=0xDEADBEEF, out_last=1 only there.
- start pulsed again at beat 10 while busy → ignored; exactly one dump of 32 (or 33) beats and one done pulse.
- rst_n asserted during the SEND of addr 12 → all outputs 0 immediately; after release with no start, out_valid stays 0 and done never pulses.
- Regfile write of 0xCAFEF00D to reg20 while ptr=10 → beat 20 reports 0xCAFEF00D.
